// File: rtl/vga_frame_ctrl_if.sv
// Avalon-MM slave bus bundle between the HPS lightweight bridge and vga_frame_ctrl.
// The master modport drives the controls; the slave modport returns registered read data.
interface vga_frame_ctrl_if;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [3:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output chipselect,
    output write,
    output read,
    output address,
    output writedata,
    input  readdata
  );

  modport slave (
    input  chipselect,
    input  write,
    input  read,
    input  address,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/vga_frame_ctrl.sv
// VGA raster timing generator plus an NREGS-deep PPU register bank, frame counter and vblank irq.
// Define VGA_FRAME_CTRL_SHADOW_EN to double-buffer the bank (host writes commit at vblank start).
module vga_frame_ctrl #(
  parameter int NREGS   = 8,
  parameter int HACTIVE = 1280,
  parameter int HFP     = 32,
  parameter int HSYNC   = 192,
  parameter int HBP     = 96,
  parameter int VACTIVE = 480,
  parameter int VFP     = 10,
  parameter int VSYNC   = 2,
  parameter int VBP     = 33,
  parameter int WIN_X0  = 160,
  parameter int WIN_X1  = 1120,
  parameter int WIN_Y1  = 400
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_frame_ctrl_if.slave      bus,
  output logic                 irq,
  output logic [10:0]          hcount,
  output logic [9:0]           vcount,
  output logic [32*NREGS-1:0]  reg_out,
  input  logic [23:0]          pix_in,
  output logic [7:0]           VGA_R,
  output logic [7:0]           VGA_G,
  output logic [7:0]           VGA_B,
  output logic                 VGA_CLK,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 VGA_BLANK_n,
  output logic                 VGA_SYNC_n
);

  localparam int HTOTAL = HACTIVE + HFP + HSYNC + HBP;
  localparam int VTOTAL = VACTIVE + VFP + VSYNC + VBP;

  localparam logic [10:0] H_LAST   = 11'(HTOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(HACTIVE);
  localparam logic [10:0] H_SYNC_S = 11'(HACTIVE + HFP);
  localparam logic [10:0] H_SYNC_E = 11'(HACTIVE + HFP + HSYNC);
  localparam logic [10:0] H_WIN_S  = 11'(WIN_X0);
  localparam logic [10:0] H_WIN_E  = 11'(WIN_X1);

  localparam logic [9:0]  V_LAST   = 10'(VTOTAL - 1);
  localparam logic [9:0]  V_ACT    = 10'(VACTIVE);
  localparam logic [9:0]  V_COMMIT = 10'(VACTIVE - 1);
  localparam logic [9:0]  V_SYNC_S = 10'(VACTIVE + VFP);
  localparam logic [9:0]  V_SYNC_E = 10'(VACTIVE + VFP + VSYNC);
  localparam logic [9:0]  V_WIN_E  = 10'(WIN_Y1);

  localparam logic [3:0]  A_CTRL   = 4'(NREGS);
  localparam logic [3:0]  A_FRAME  = 4'(NREGS + 1);

  logic [10:0] r_hcount;
  logic [9:0]  r_vcount;
  logic        r_irq_en;
  logic        r_pending;
  logic [31:0] r_frame;
  logic [31:0] r_readdata;

  logic        w_commit;
  logic        w_wr;
  logic        w_rd;
  logic        w_wr_ctrl;
  logic        w_blank_n;
  logic        w_in_win;
  logic [31:0] w_rd_mux;
  logic [31:0] w_bank_rd [NREGS];

  // Raster counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (r_hcount == H_LAST) begin
      r_hcount <= '0;
      r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + 10'd1;
    end else begin
      r_hcount <= r_hcount + 11'd1;
    end
  end

  // Last cycle of the final active line: vertical blanking starts on the next edge.
  assign w_commit  = (r_hcount == H_LAST) && (r_vcount == V_COMMIT);

  assign w_wr      = bus.chipselect && bus.write;
  assign w_rd      = bus.chipselect && bus.read;
  assign w_wr_ctrl = w_wr && (bus.address == A_CTRL);

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      localparam logic [3:0] A_REG = 4'(gi);

      logic        w_sel;
      logic [31:0] r_active;

      assign w_sel = w_wr && (bus.address == A_REG);

`ifdef VGA_FRAME_CTRL_SHADOW_EN
      logic [31:0] r_shadow;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_shadow <= '0;
        end else if (w_sel) begin
          r_shadow <= bus.writedata;
        end
      end

      // A write landing in the commit cycle misses this frame: r_shadow still holds the old value here.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_active <= '0;
        end else if (w_commit) begin
          r_active <= r_shadow;
        end
      end

      assign w_bank_rd[gi] = r_shadow;
`else
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_active <= '0;
        end else if (w_sel) begin
          r_active <= bus.writedata;
        end
      end

      assign w_bank_rd[gi] = r_active;
`endif

      assign reg_out[32*gi +: 32] = r_active;
    end
  endgenerate

  // Commit sets pending with priority over a same-cycle write-1-to-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_en  <= 1'b0;
      r_pending <= 1'b0;
      r_frame   <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_irq_en <= bus.writedata[0];
      end
      if (w_commit) begin
        r_pending <= 1'b1;
      end else if (w_wr_ctrl && bus.writedata[1]) begin
        r_pending <= 1'b0;
      end
      if (w_commit) begin
        r_frame <= r_frame + 32'd1;
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (bus.address == 4'(k)) begin
        w_rd_mux = w_bank_rd[k];
      end
    end
    if (bus.address == A_CTRL) begin
      w_rd_mux = {30'd0, r_pending, r_irq_en};
    end else if (bus.address == A_FRAME) begin
      w_rd_mux = r_frame;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata <= '0;
    end else if (w_rd) begin
      r_readdata <= w_rd_mux;
    end
  end

  assign bus.readdata = r_readdata;
  assign irq          = r_pending && r_irq_en;
  assign hcount       = r_hcount;
  assign vcount       = r_vcount;

  assign w_blank_n = (r_hcount < H_ACT) && (r_vcount < V_ACT);
  assign w_in_win  = w_blank_n && (r_hcount >= H_WIN_S) && (r_hcount < H_WIN_E) && (r_vcount < V_WIN_E);

  assign VGA_R       = w_in_win ? pix_in[23:16] : 8'd0;
  assign VGA_G       = w_in_win ? pix_in[15:8]  : 8'd0;
  assign VGA_B       = w_in_win ? pix_in[7:0]   : 8'd0;
  assign VGA_CLK     = r_hcount[0];
  assign VGA_HS      = !((r_hcount >= H_SYNC_S) && (r_hcount < H_SYNC_E));
  assign VGA_VS      = !((r_vcount >= V_SYNC_S) && (r_vcount < V_SYNC_E));
  assign VGA_BLANK_n = w_blank_n;
  assign VGA_SYNC_n  = 1'b0;

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Directed bench for vga_frame_ctrl on a shrunken raster (24 x 10 clk-cycles/lines per frame).
module tb_vga_frame_ctrl;
  localparam int NREGS = 4;
  localparam int HTOT  = 24;
  localparam int VTOT  = 10;
  localparam int CH = 23;   // commit cycle hcount
  localparam int CV = 5;    // commit cycle vcount
  localparam logic [3:0] A_CTRL  = 4'd4;
  localparam logic [3:0] A_FRAME = 4'd5;
`ifdef VGA_FRAME_CTRL_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic irq;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [32*NREGS-1:0] reg_out;
  logic [23:0] pix_in = 24'hFF8040;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rd;

  vga_frame_ctrl_if bus_if();

  vga_frame_ctrl #(
    .NREGS(NREGS), .HACTIVE(16), .HFP(2), .HSYNC(4), .HBP(2),
    .VACTIVE(6), .VFP(1), .VSYNC(2), .VBP(1),
    .WIN_X0(4), .WIN_X1(12), .WIN_Y1(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus_if), .irq(irq),
    .hcount(hcount), .vcount(vcount), .reg_out(reg_out), .pix_in(pix_in),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b), .VGA_CLK(vga_clk),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs), .VGA_BLANK_n(vga_blank_n), .VGA_SYNC_n(vga_sync_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (h=%0d v=%0d)", tag, obs, exp, hcount, vcount);
    end else begin
      $display("ok   %s: %h (h=%0d v=%0d)", tag, obs, hcount, vcount);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hv(input int h, input int v);
    int n = 0;
    while (!(hcount == 11'(h) && vcount == 10'(v)) && n < 3 * HTOT * VTOT) begin
      tick();
      n++;
    end
    if (!(hcount == 11'(h) && vcount == 10'(v))) chk("wait_timeout", {hcount, 11'd0, vcount}, {11'(h), 11'd0, 10'(v)});
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus_if.chipselect = 1'b1;
    bus_if.write      = 1'b1;
    bus_if.address    = a;
    bus_if.writedata  = d;
    tick();
    bus_if.chipselect = 1'b0;
    bus_if.write      = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus_if.chipselect = 1'b1;
    bus_if.read       = 1'b1;
    bus_if.address    = a;
    tick();
    bus_if.chipselect = 1'b0;
    bus_if.read       = 1'b0;
    d = bus_if.readdata;
  endtask

  task automatic pulse_reset();
    #3 reset = 1'b1;
    #1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int cnt;
    bus_if.chipselect = 1'b0;
    bus_if.write      = 1'b0;
    bus_if.read       = 1'b0;
    bus_if.address    = '0;
    bus_if.writedata  = '0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 30; i++) tick();

    // Asynchronous reset mid-line
    #3 reset = 1'b1;
    #1;
    chk("async_rst_hcount", 32'(hcount), 32'd0);
    chk("async_rst_vcount", 32'(vcount), 32'd0);
    tick(); tick();
    reset = 1'b0;
    chk("rst_hs", 32'(vga_hs), 32'd1);
    chk("rst_vs", 32'(vga_vs), 32'd1);
    chk("rst_blank_n", 32'(vga_blank_n), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_reg_out0", reg_out[31:0], 32'd0);
    chk("rst_readdata", bus_if.readdata, 32'd0);
    chk("rst_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
    chk("sync_n", 32'(vga_sync_n), 32'd0);

    // First VS low: vcount 7 after 7*24 cycles
    cnt = 0;
    while (vga_vs && cnt < 1000) begin
      tick();
      cnt++;
    end
    chk("first_vs_cycles", 32'(cnt), 32'd168);
    chk("first_vs_vcount", 32'(vcount), 32'd7);
    wait_hv(17, 7);  chk("hs_h17", 32'(vga_hs), 32'd1);
    tick();          chk("hs_h18", 32'(vga_hs), 32'd0);
    wait_hv(21, 7);  chk("hs_h21", 32'(vga_hs), 32'd0);
    tick();          chk("hs_h22", 32'(vga_hs), 32'd1);
    wait_hv(23, 8);  chk("vs_v8", 32'(vga_vs), 32'd0);
    tick();          chk("vs_v9", 32'(vga_vs), 32'd1);
    bus_read(A_FRAME, rd); chk("frame_after_first", rd, 32'd1);

    // Register write mid-frame
    wait_hv(0, 1);
    bus_write(4'd2, 32'hDEADBEEF);
    chk("reg2_after_write", reg_out[95:64], SHADOW ? 32'd0 : 32'hDEADBEEF);
    bus_read(4'd2, rd); chk("reg2_read", rd, 32'hDEADBEEF);
    wait_hv(CH, CV);  chk("reg2_pre_commit", reg_out[95:64], SHADOW ? 32'd0 : 32'hDEADBEEF);
    tick();           chk("reg2_post_commit", reg_out[95:64], 32'hDEADBEEF);

    // Write in the commit cycle
    wait_hv(CH, CV);
    bus_write(4'd0, 32'h12345678);
    chk("reg0_commit_write", reg_out[31:0], SHADOW ? 32'd0 : 32'h12345678);
    bus_read(4'd0, rd); chk("reg0_read", rd, 32'h12345678);
    wait_hv(CH, CV);
    tick();
    chk("reg0_next_commit", reg_out[31:0], 32'h12345678);
    chk("reg2_kept", reg_out[95:64], 32'hDEADBEEF);

    // Reset clears bank, then irq per frame
    pulse_reset();
    chk("rst2_reg0", reg_out[31:0], 32'd0);
    chk("rst2_reg2", reg_out[95:64], 32'd0);
    bus_read(A_FRAME, rd); chk("rst2_frame", rd, 32'd0);
    bus_write(A_CTRL, 32'd1);
    for (int f = 0; f < 3; f++) begin
      wait_hv(CH, CV);  chk("irq_pre_commit", 32'(irq), 32'd0);
      tick();           chk("irq_post_commit", 32'(irq), 32'd1);
      bus_write(A_CTRL, 32'd3);
      chk("irq_cleared", 32'(irq), 32'd0);
    end
    bus_read(A_FRAME, rd); chk("frame_3", rd, 32'd3);
    bus_read(A_CTRL, rd);  chk("ctrl_en_only", rd, 32'd1);

    // Clear in commit cycle loses to set; FRAME read in commit cycle is pre-increment
    wait_hv(CH, CV);
    bus_write(A_CTRL, 32'd3);
    chk("irq_set_wins", 32'(irq), 32'd1);
    bus_read(A_CTRL, rd);  chk("ctrl_pending", rd, 32'd3);
    wait_hv(CH, CV);
    bus_read(A_FRAME, rd); chk("frame_in_commit", rd, 32'd4);
    bus_read(A_FRAME, rd); chk("frame_after", rd, 32'd5);
    tick(); tick();
    chk("readdata_hold", bus_if.readdata, 32'd5);

    // Window-gated RGB
    pix_in = 24'hFF8040;
    wait_hv(3, 0);   chk("rgb_h3", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
                     chk("vga_clk_h3", 32'(vga_clk), 32'd1);
    wait_hv(4, 0);   chk("rgb_h4", {8'd0, vga_r, vga_g, vga_b}, 32'h00FF8040);
                     chk("vga_clk_h4", 32'(vga_clk), 32'd0);
    wait_hv(11, 0);  chk("rgb_h11", {8'd0, vga_r, vga_g, vga_b}, 32'h00FF8040);
    wait_hv(12, 0);  chk("rgb_h12", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
    wait_hv(15, 0);  chk("blank_h15", 32'(vga_blank_n), 32'd1);
    wait_hv(16, 0);  chk("blank_h16", 32'(vga_blank_n), 32'd0);
    wait_hv(11, 3);  chk("rgb_v3", {8'd0, vga_r, vga_g, vga_b}, 32'h00FF8040);
    wait_hv(4, 4);   chk("rgb_v4", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
                     chk("blank_v4", 32'(vga_blank_n), 32'd1);
    wait_hv(0, 6);   chk("blank_v6", 32'(vga_blank_n), 32'd0);

    // Unmapped address
    wait_hv(0, 7);
    bus_write(4'd1, 32'hA5A5A5A5);
    bus_write(4'd15, 32'hFFFFFFFF);
    bus_read(4'd15, rd); chk("read_addr15", rd, 32'd0);
    bus_read(4'd1, rd);  chk("reg1_intact", rd, 32'hA5A5A5A5);
    bus_read(4'd6, rd);  chk("read_addr6", rd, 32'd0);
    bus_read(A_CTRL, rd); chk("ctrl_intact", rd, 32'd3);
    chk("reg3_intact", reg_out[127:96], 32'd0);
    chk("reg1_active", reg_out[63:32], SHADOW ? 32'd0 : 32'hA5A5A5A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
